// File: rtl/seq_div_unit.sv
// Signed 32-bit restoring divider: quotient on lo_out, remainder on hi_out, div_zero on b==0.
// Latency: start edge N, 32 CALC edges, FIX edge N+33; done and results visible after N+33.
// Backpressure: none; start is only honoured in IDLE, otherwise ignored (busy high in CALC/FIX).
module seq_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        ZERO
    } divState_t;

    divState_t        state;
    divState_t        stateNext;

    logic [WIDTH-1:0] dvd;        // dividend magnitude, becomes the quotient bit by bit
    logic [WIDTH-1:0] dvs;        // divisor magnitude
    logic [WIDTH-1:0] rem;        // partial remainder
    logic [CntW-1:0]  cnt;
    logic             signQ;
    logic             signR;

    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   trialDiff;
    logic             fitsTrial;
    logic             divByZero;

    // Operand magnitudes and one restoring step; the 33-bit subtract borrow doubles as the compare.
    always_comb begin
        absA      = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
        absB      = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;
        divByZero = (b_in == '0);
        trial     = {rem, dvd[WIDTH-1]};
        trialDiff = trial - {1'b0, dvs};
        fitsTrial = ~trialDiff[WIDTH];
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic plus the state-decoded busy and div_zero outputs.
    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        div_zero  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = divByZero ? ZERO : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == CntLast) begin
                    stateNext = FIX;
                end
            end
            FIX: begin
                busy      = 1'b1;
                stateNext = IDLE;
            end
            ZERO: begin
                div_zero  = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Datapath: latch magnitudes on start, iterate in CALC, apply signs and pulse done in FIX.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            cnt    <= '0;
            signQ  <= 1'b0;
            signR  <= 1'b0;
            lo_out <= '0;
            hi_out <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !divByZero) begin
                        dvd   <= absA;
                        dvs   <= absB;
                        rem   <= '0;
                        cnt   <= '0;
                        signQ <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        signR <= a_in[WIDTH-1];
                    end
                end
                CALC: begin
                    dvd <= {dvd[WIDTH-2:0], fitsTrial};
                    rem <= fitsTrial ? trialDiff[WIDTH-1:0] : trial[WIDTH-1:0];
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    // Negation wraps mod 2^WIDTH, so MIN/-1 yields MIN without any flag.
                    lo_out <= signQ ? (~dvd + 1'b1) : dvd;
                    hi_out <= signR ? (~rem + 1'b1) : rem;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_unit.sv
// Directed bench for seq_div_unit: reset, latency, signs, overflow wrap, zero divisor, abort, ignored start.
// Every expectation is a hand-computed constant.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seq_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] aIn;
    logic [31:0] bIn;
    logic [31:0] loOut;
    logic [31:0] hiOut;
    logic        busy;
    logic        done;
    logic        divZero;

    int nAsserts = 0;
    int nFails   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    // Hand-computed: quotient truncated toward zero, remainder carries the dividend sign.
    vec_t vecs [12] = '{
        '{32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001},  //  7 / -2
        '{32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF},  // -7 /  2
        '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000}, // MIN / -1 wraps
        '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF}, // -1 / MIN
        '{32'd100,      32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'h0000_0002},  // 100 / -7
        '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 32'hFFFF_FFFE}, // -100 / -7
        '{32'd0,        32'd5,         32'h0000_0000, 32'h0000_0000},  // 0 / 5
        '{32'd5,        32'd7,         32'h0000_0000, 32'h0000_0005},  // 5 / 7
        '{32'h7FFF_FFFF, 32'd1,        32'h7FFF_FFFF, 32'h0000_0000},  // MAX / 1
        '{32'h8000_0000, 32'd2,        32'hC000_0000, 32'h0000_0000},  // MIN / 2
        '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000}, // MIN / MIN
        '{32'd12345,    32'hFFFF_FFFF, 32'hFFFF_CFC7, 32'h0000_0000}   // 12345 / -1
    };

    always #5 clock = ~clock;

    seq_div_unit #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .a_in     (aIn),
        .b_in     (bIn),
        .lo_out   (loOut),
        .hi_out   (hiOut),
        .busy     (busy),
        .done     (done),
        .div_zero (divZero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; drives start for one cycle and counts edges until done (bounded).
    task automatic runDiv(input logic [31:0] a, input logic [31:0] b,
                          output int edges, output logic busyEarly);
        start     = 1'b1;
        aIn       = a;
        bIn       = b;
        edges     = 0;
        busyEarly = 1'b0;
        do begin
            @(negedge clock);
            start = 1'b0;
            edges++;
            if (edges == 1) busyEarly = busy;
        end while (!done && edges < 100);
    endtask

    initial begin : stim
        int   edges;
        logic busyEarly;
        logic sawDone;

        reset = 1'b1;
        start = 1'b0;
        aIn   = '0;
        bIn   = '0;
        repeat (2) @(negedge clock);
        check("reset_lo",      loOut,          32'h0);
        check("reset_hi",      hiOut,          32'h0);
        check("reset_busy",    {31'b0, busy},    32'h0);
        check("reset_done",    {31'b0, done},    32'h0);
        check("reset_divzero", {31'b0, divZero}, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // 7 / 2: done after exactly 34 edges counting the start edge.
        runDiv(32'd7, 32'd2, edges, busyEarly);
        check("7div2_edges",     32'(edges),       32'd34);
        check("7div2_busyEarly", {31'b0, busyEarly}, 32'h1);
        check("7div2_lo",        loOut,            32'h3);
        check("7div2_hi",        hiOut,            32'h1);
        check("7div2_busyDone",  {31'b0, busy},      32'h0);

        // Zero divisor, started in the done cycle: one-cycle div_zero, results kept.
        start = 1'b1;
        aIn   = 32'd9;
        bIn   = 32'd0;
        @(negedge clock);
        start = 1'b0;
        check("zero_pulse", {31'b0, divZero}, 32'h1);
        check("zero_busy",  {31'b0, busy},    32'h0);
        check("zero_done",  {31'b0, done},    32'h0);
        @(negedge clock);
        check("zero_clear", {31'b0, divZero}, 32'h0);
        check("zero_done2", {31'b0, done},    32'h0);
        check("zero_lo",    loOut,            32'h3);
        check("zero_hi",    hiOut,            32'h1);

        // Directed table, each started in the previous done cycle (back-to-back).
        for (int i = 0; i < 12; i++) begin
            runDiv(vecs[i].a, vecs[i].b, edges, busyEarly);
            check($sformatf("vec%0d_edges", i), 32'(edges), 32'd34);
            check($sformatf("vec%0d_lo", i),    loOut,      vecs[i].lo);
            check($sformatf("vec%0d_hi", i),    hiOut,      vecs[i].hi);
        end

        // Reset during CALC of 100/3 aborts immediately with no done.
        @(negedge clock);
        start = 1'b1;
        aIn   = 32'd100;
        bIn   = 32'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort_lo",      loOut,            32'h0);
        check("abort_hi",      hiOut,            32'h0);
        check("abort_busy",    {31'b0, busy},    32'h0);
        check("abort_done",    {31'b0, done},    32'h0);
        check("abort_divzero", {31'b0, divZero}, 32'h0);
        @(negedge clock);
        reset   = 1'b0;
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge clock);
            sawDone |= done;
        end
        check("abort_noDone", {31'b0, sawDone}, 32'h0);
        runDiv(32'd100, 32'd3, edges, busyEarly);
        check("restart_edges", 32'(edges), 32'd34);
        check("restart_lo",    loOut,      32'd33);
        check("restart_hi",    hiOut,      32'd1);

        // A second start mid-CALC (different operands) must not disturb 1000/7.
        @(negedge clock);
        start = 1'b1;
        aIn   = 32'd1000;
        bIn   = 32'd7;
        edges = 0;
        do begin
            @(negedge clock);
            edges++;
            start = (edges == 5);
            if (edges == 5) begin
                aIn = 32'd50;
                bIn = 32'd5;
            end
        end while (!done && edges < 100);
        start = 1'b0;
        check("ignore_edges", 32'(edges), 32'd34);
        check("ignore_lo",    loOut,      32'd142);
        check("ignore_hi",    hiOut,      32'd6);
        repeat (3) @(negedge clock);
        check("ignore_idle",  {31'b0, busy}, 32'h0);
        check("ignore_hold",  loOut,         32'd142);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
